// File: rtl/buffered_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : buffered_mul_pkg
// Purpose  : Shared widths, FSM state encoding and helpers for the
//            multiply-accumulate batch block with taint tracking.
// Revision : 1.0  initial release
// ============================================================================
package buffered_mul_pkg;

    localparam int OPND_W = 4;
    localparam int PROD_W = 8;
    localparam int LEN_W  = 4;
    localparam int SUM_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Zero-extend a product to the accumulator width.
    function automatic logic [SUM_W-1:0] widen_prod(input logic [PROD_W-1:0] p);
        return {{(SUM_W-PROD_W){1'b0}}, p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/taint_sticky.sv
`default_nettype none
// ============================================================================
// Module   : taint_sticky
// Purpose  : One-bit sticky taint register; OR-accumulates set, cleared by rst.
// Revision : 1.0  initial release
// ============================================================================
module taint_sticky (
    input  logic clk,
    input  logic rst,
    input  logic set,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= r_q | set;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mul_accum_taint.sv
`default_nettype none
// ============================================================================
// Module   : mul_accum_taint
// Purpose  : Accumulates a batch of in_len products into a 12-bit sum and
//            tracks control/data taint alongside the result.
// Revision : 1.0  initial release
// ============================================================================
module mul_accum_taint
    import buffered_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              start_t,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_len_t,
    input  logic              in_valid,
    input  logic              in_valid_t,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_data_t,
    output logic              busy,
    output logic              busy_t,
    output logic              out_valid,
    output logic              out_valid_t,
    output logic [SUM_W-1:0]  out_sum,
    output logic              out_sum_t
);

    state_t             r_state;
    logic [LEN_W-1:0]   r_len_q;
    logic [LEN_W-1:0]   r_cnt;
    logic [SUM_W-1:0]   r_sum;
    logic [LEN_W-1:0]   w_cnt_next;
    logic               w_ctl_t;
    logic               w_sum_t;

    assign w_cnt_next = r_cnt + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_len_q <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len_q <= in_len;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_state <= (in_len == '0) ? ST_DONE : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        r_sum <= r_sum + widen_prod(in_data);
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == r_len_q) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so they are glitch-free.
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = r_sum;

    // Data taint never reaches the control taint: data does not steer the FSM.
    taint_sticky u_ctl_t (
        .clk (clk),
        .rst (rst),
        .set (start_t | in_len_t | in_valid_t),
        .q   (w_ctl_t)
    );

    taint_sticky u_sum_t (
        .clk (clk),
        .rst (rst),
        .set (in_data_t | in_valid_t | w_ctl_t),
        .q   (w_sum_t)
    );

    assign busy_t      = w_ctl_t;
    assign out_valid_t = w_ctl_t;
    assign out_sum_t   = w_sum_t;

endmodule
`default_nettype wire

// File: tb/tb_mul_accum_taint.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_accum_taint
// Purpose  : Self-checking bench for mul_accum_taint against a batch-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_accum_taint;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start_t = 1'b0;
    logic [3:0]  in_len = '0;
    logic        in_len_t = 1'b0;
    logic        in_valid = 1'b0, in_valid_t = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_data_t = 1'b0;
    logic        busy, busy_t, out_valid, out_valid_t, out_sum_t;
    logic [11:0] out_sum;

    int n_checks = 0;
    int n_errs   = 0;
    int n_done   = 0;

    // Reference model: batch phase, products still owed, running total, taints.
    localparam int P_IDLE = 0, P_ACC = 1, P_DONE = 2;
    int m_phase = P_IDLE;
    int m_left  = 0;
    int m_sum   = 0;
    bit m_ctl_t = 1'b0;
    bit m_sum_t = 1'b0;

    mul_accum_taint dut (
        .clk(clk), .rst(rst),
        .start(start), .start_t(start_t),
        .in_len(in_len), .in_len_t(in_len_t),
        .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_data(in_data), .in_data_t(in_data_t),
        .busy(busy), .busy_t(busy_t),
        .out_valid(out_valid), .out_valid_t(out_valid_t),
        .out_sum(out_sum), .out_sum_t(out_sum_t)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_phase = P_IDLE; m_left = 0; m_sum = 0; m_ctl_t = 0; m_sum_t = 0;
        end else begin
            m_sum_t = m_sum_t | in_data_t | in_valid_t | m_ctl_t;
            m_ctl_t = m_ctl_t | start_t | in_len_t | in_valid_t;
            if (m_phase == P_DONE) begin
                m_phase = P_IDLE;
            end else if (m_phase == P_IDLE && start) begin
                m_sum   = 0;
                m_left  = int'(in_len);
                m_phase = (m_left == 0) ? P_DONE : P_ACC;
            end else if (m_phase == P_ACC && in_valid) begin
                m_sum  = m_sum + int'(in_data);
                m_left = m_left - 1;
                if (m_left == 0) m_phase = P_DONE;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("busy",        32'(busy),        32'(m_phase != P_IDLE));
        check_eq("out_valid",   32'(out_valid),   32'(m_phase == P_DONE));
        check_eq("out_sum",     32'(out_sum),     32'(m_sum));
        check_eq("busy_t",      32'(busy_t),      32'(m_ctl_t));
        check_eq("out_valid_t", 32'(out_valid_t), 32'(m_ctl_t));
        check_eq("out_sum_t",   32'(out_sum_t),   32'(m_sum_t));
        if (out_valid === 1'b1) n_done++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic clear_inputs();
        start = 0; start_t = 0; in_len = '0; in_len_t = 0;
        in_valid = 0; in_valid_t = 0; in_data = '0; in_data_t = 0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1; step(); step(); rst = 0;
    endtask

    task automatic begin_batch(input logic [3:0] len, input logic len_t);
        start = 1; in_len = len; in_len_t = len_t;
        step();
        start = 0; in_len = '0; in_len_t = 0;
    endtask

    task automatic product(input logic [7:0] d, input logic dt);
        in_valid = 1; in_data = d; in_data_t = dt;
        step();
        in_valid = 0; in_data = '0; in_data_t = 0;
    endtask

    initial begin
        int pulses;
        reset_dut();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_sum", 32'(out_sum), 0);
        check_eq("rst_taint", 32'({busy_t, out_valid_t, out_sum_t}), 0);

        // Three products, consecutive cycles.
        begin_batch(4'd3, 0);
        product(8'd6, 0); product(8'd0, 0); product(8'd9, 0);
        check_eq("b3_valid", 32'(out_valid), 1);
        check_eq("b3_sum", 32'(out_sum), 15);
        step();
        check_eq("b3_busy_after", 32'(busy), 0);
        check_eq("b3_sum_hold", 32'(out_sum), 15);

        // Zero-length batch completes immediately; stray products are ignored.
        begin_batch(4'd0, 0);
        check_eq("b0_valid", 32'(out_valid), 1);
        check_eq("b0_sum", 32'(out_sum), 0);
        product(8'd50, 0);
        check_eq("b0_idle", 32'(busy), 0);
        check_eq("b0_sum_hold", 32'(out_sum), 0);

        // Full-length batch of maximum products with random gaps.
        reset_dut();
        pulses = n_done;
        begin_batch(4'd15, 0);
        for (int i = 0; i < 15; i++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            product(8'd255, 0);
        end
        check_eq("b15_sum", 32'(out_sum), 3825);
        for (int i = 0; i < 4; i++) step();
        check_eq("b15_pulses", 32'(n_done - pulses), 1);

        // Data taint reaches only the sum taint.
        reset_dut();
        begin_batch(4'd3, 0);
        product(8'd1, 1); product(8'd2, 1); product(8'd3, 1);
        step();
        check_eq("dt_sum_t", 32'(out_sum_t), 1);
        check_eq("dt_ctl_t", 32'({busy_t, out_valid_t}), 0);

        // Length taint makes control taint sticky until reset.
        reset_dut();
        begin_batch(4'd2, 1);
        check_eq("lt_busy_t", 32'(busy_t), 1);
        product(8'd4, 0); product(8'd5, 0);
        for (int i = 0; i < 3; i++) step();
        check_eq("lt_valid_t", 32'(out_valid_t), 1);
        reset_dut();
        check_eq("lt_cleared", 32'({busy_t, out_valid_t, out_sum_t}), 0);

        // Reset aborts a batch mid-flight without a done pulse.
        begin_batch(4'd4, 0);
        product(8'd1, 0); product(8'd2, 0);
        pulses = n_done;
        rst = 1; step(); rst = 0;
        check_eq("ab_busy", 32'(busy), 0);
        step(); step();
        check_eq("ab_no_valid", 32'(n_done - pulses), 0);
        begin_batch(4'd1, 0);
        product(8'd7, 0);
        check_eq("ab_new_valid", 32'(out_valid), 1);
        check_eq("ab_new_sum", 32'(out_sum), 7);
        step();

        // Randomized batches with stray start/valid and occasional taints.
        for (int b = 0; b < 40; b++) begin
            int budget;
            if ($urandom_range(0, 1) == 0) reset_dut();
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1; in_data = 8'($urandom); step(); in_valid = 0;
            end
            begin_batch(4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
            budget = 0;
            while (m_phase != P_IDLE && budget < 80) begin
                in_valid   = ($urandom_range(0, 1) == 1);
                in_data    = 8'($urandom);
                in_data_t  = ($urandom_range(0, 15) == 0);
                in_valid_t = ($urandom_range(0, 31) == 0);
                start      = ($urandom_range(0, 7) == 0);
                in_len     = 4'($urandom);
                step();
                budget++;
            end
            clear_inputs();
            check_eq("rnd_budget", 32'(budget < 80), 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
